// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the add_sub arbiter slice.
`default_nettype none

package alu_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_EXEC = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_t;

   localparam logic OP_ADD  = 1'b0;
   localparam logic OP_SUB  = 1'b1;
   localparam int   OPCNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/add_sub.sv
// add_sub: combinational signed adder/subtractor, result one bit wider than operands.
`default_nettype none

module add_sub
   import alu_pkg::*;
#(
   parameter int DATAW = 8
) (
   input  logic [DATAW-1:0] a_i,
   input  logic [DATAW-1:0] b_i,
   input  logic             op_i,
   output logic [DATAW:0]   result_o
);

   logic [DATAW:0] a_ext;
   logic [DATAW:0] b_ext;

   assign a_ext    = {a_i[DATAW-1], a_i};
   assign b_ext    = {b_i[DATAW-1], b_i};
   assign result_o = (op_i == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);

endmodule

`default_nettype wire

// File: rtl/add_sub_arbiter.sv
// add_sub_arbiter: round-robin sharing of one add_sub among NREQ requesters.
// Build option: define ADD_SUB_ARB_STATS_EN to enable the saturating o_op_count counter.
`default_nettype none

module add_sub_arbiter
   import alu_pkg::*;
#(
   parameter  int DATAW = 8,
   parameter  int NREQ  = 4,
   localparam int IDW   = $clog2(NREQ)
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [NREQ-1:0]         i_req_valid,
   output logic [NREQ-1:0]         o_req_ready,
   input  logic [NREQ*DATAW-1:0]   i_req_dataa,
   input  logic [NREQ*DATAW-1:0]   i_req_datab,
   input  logic [NREQ-1:0]         i_req_op,
   output logic                    o_rsp_valid,
   input  logic                    i_rsp_ready,
   output logic [DATAW:0]          o_rsp_result,
   output logic [IDW-1:0]          o_rsp_id,
   output logic [OPCNT_W-1:0]      o_op_count
);

   // Scan from last+1 upward; descending loop lets the closest requester win.
   function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                              input logic [IDW-1:0]  last);
      logic [IDW-1:0] w;
      logic [IDW-1:0] k;
      int             idx;
      w = last;
      for (int i = NREQ; i >= 1; i--) begin
         idx = (int'(last) + i) % NREQ;
         k   = IDW'(idx);
         if (v[k]) w = k;
      end
      return w;
   endfunction

   arb_state_t       state_q, state_d;
   logic [IDW-1:0]   last_q, last_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [DATAW-1:0] a_q, a_d;
   logic [DATAW-1:0] b_q, b_d;
   logic             op_q, op_d;
   logic [DATAW:0]   res_q, res_d;
   logic [DATAW:0]   alu_res;
   logic [IDW-1:0]   winner;

   assign winner = rr_pick(i_req_valid, last_q);

   add_sub #(.DATAW(DATAW)) u_add_sub (
      .a_i      (a_q),
      .b_i      (b_q),
      .op_i     (op_q),
      .result_o (alu_res)
   );

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      id_d        = id_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      res_d       = res_q;
      o_req_ready = '0;
      case (state_q)
         ARB_IDLE: begin
            if (|i_req_valid) begin
               o_req_ready[winner] = 1'b1;
               last_d  = winner;
               id_d    = winner;
               a_d     = i_req_dataa[int'(winner)*DATAW +: DATAW];
               b_d     = i_req_datab[int'(winner)*DATAW +: DATAW];
               op_d    = i_req_op[winner];
               state_d = ARB_EXEC;
            end
         end
         ARB_EXEC: begin
            res_d   = alu_res;
            state_d = ARB_RESP;
         end
         ARB_RESP: begin
            if (i_rsp_ready) state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ARB_IDLE;
         last_q  <= IDW'(NREQ - 1);
         id_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= OP_ADD;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         id_q    <= id_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         res_q   <= res_d;
      end
   end

   // Valid is decoded from state so reset drops it without waiting for a clock.
   assign o_rsp_valid  = (state_q == ARB_RESP);
   assign o_rsp_result = res_q;
   assign o_rsp_id     = id_q;

`ifdef ADD_SUB_ARB_STATS_EN
   logic [OPCNT_W-1:0] cnt_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q <= '0;
      end else if (o_rsp_valid && i_rsp_ready && (cnt_q != {OPCNT_W{1'b1}})) begin
         cnt_q <= cnt_q + OPCNT_W'(1);
      end
   end

   assign o_op_count = cnt_q;
`else
   assign o_op_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_add_sub_arbiter.sv
// tb_add_sub_arbiter: scoreboard bench for add_sub_arbiter (DATAW=8, NREQ=4).
`default_nettype none

module tb_add_sub_arbiter;

`ifdef ADD_SUB_ARB_STATS_EN
   localparam bit STATS_EN = 1'b1;
`else
   localparam bit STATS_EN = 1'b0;
`endif

   logic        clk       = 1'b0;
   logic        rst       = 1'b1;
   logic [3:0]  req_valid = 4'b0;
   logic [3:0]  req_ready;
   logic [31:0] dataa     = '0;
   logic [31:0] datab     = '0;
   logic [3:0]  req_op    = 4'b0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [8:0]  rsp_result;
   logic [1:0]  rsp_id;
   logic [15:0] op_count;

   add_sub_arbiter #(.DATAW(8), .NREQ(4)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_req_dataa  (dataa),
      .i_req_datab  (datab),
      .i_req_op     (req_op),
      .o_rsp_valid  (rsp_valid),
      .i_rsp_ready  (rsp_ready),
      .o_rsp_result (rsp_result),
      .o_rsp_id     (rsp_id),
      .o_op_count   (op_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] id;
      logic [8:0] res;
   } exp_t;

   exp_t sb[$];
   int   glog[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   mstate   = 0;
   int   mlast    = 3;
   int   mcount   = 0;
   int   hs_cnt   = 0;
   int   rsp_cnt  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int rr(input logic [3:0] v, input int last);
      for (int i = 1; i <= 4; i++) begin
         if (v[(last + i) % 4]) return (last + i) % 4;
      end
      return -1;
   endfunction

   function automatic logic [8:0] calc(input logic [7:0] a, input logic [7:0] b, input logic op);
      logic [8:0] sa;
      logic [8:0] sb_;
      sa  = {a[7], a};
      sb_ = {b[7], b};
      return op ? (sa - sb_) : (sa + sb_);
   endfunction

   // Reference model, advanced once per cycle between clock edges.
   always @(negedge clk) begin
      logic [3:0] exp_rdy;
      int         w;
      exp_t       e;
      if (!rst) begin
         exp_rdy = 4'b0;
         w = rr(req_valid, mlast);
         if (mstate == 0 && w >= 0) exp_rdy[w] = 1'b1;
         check("ready", {28'b0, req_ready}, {28'b0, exp_rdy});
         check("rsp_valid", {31'b0, rsp_valid}, (mstate == 2) ? 32'd1 : 32'd0);
         check("op_count", {16'b0, op_count}, STATS_EN ? mcount : 0);
         if (mstate == 2) begin
            if (sb.size() == 0) begin
               check("sb_empty", 32'd0, 32'd1);
            end else begin
               check("result", {23'b0, rsp_result}, {23'b0, sb[0].res});
               check("id", {30'b0, rsp_id}, {30'b0, sb[0].id});
            end
         end
         case (mstate)
            0: if (w >= 0) begin
                  e.id  = 2'(w);
                  e.res = calc(dataa[w*8 +: 8], datab[w*8 +: 8], req_op[w]);
                  sb.push_back(e);
                  glog.push_back(w);
                  mlast  = w;
                  mstate = 1;
                  hs_cnt++;
               end
            1: mstate = 2;
            default: if (rsp_ready) begin
                  if (sb.size() > 0) void'(sb.pop_front());
                  if (mcount < 16'hFFFF) mcount++;
                  mstate = 0;
                  rsp_cnt++;
               end
         endcase
      end
   end

   task automatic model_reset();
      sb.delete();
      mstate  = 0;
      mlast   = 3;
      mcount  = 0;
      rsp_cnt = hs_cnt;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b, input logic op);
      dataa[id*8 +: 8] = a;
      datab[id*8 +: 8] = b;
      req_op[id]       = op;
      req_valid[id]    = 1'b1;
   endtask

   // Returns just after the edge on which the target handshake count is reached.
   task automatic wait_hs(input int target);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); #1;
         if (hs_cnt >= target) break;
      end
      if (hs_cnt < target) check("hs_timeout", hs_cnt, target);
      @(posedge clk); #1;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); #1;
         if (rsp_cnt == hs_cnt) break;
      end
      if (rsp_cnt != hs_cnt) check("rsp_timeout", rsp_cnt, hs_cnt);
      @(posedge clk); #1;
   endtask

   task automatic run_single(input int id, input logic [7:0] a, input logic [7:0] b,
                             input logic op, input logic [8:0] exp);
      int h;
      h = hs_cnt;
      set_req(id, a, b, op);
      wait_hs(h + 1);
      req_valid[id] = 1'b0;
      check("lat_exec", {31'b0, rsp_valid}, 32'd0);
      @(posedge clk); #1;
      check("lat_resp", {31'b0, rsp_valid}, 32'd1);
      check("single_res", {23'b0, rsp_result}, {23'b0, exp});
      check("single_id", {30'b0, rsp_id}, id);
      wait_drain();
   endtask

   initial begin
      int h;
      int exp_order[8] = '{0, 1, 2, 3, 1, 3, 1, 3};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst_result", {23'b0, rsp_result}, 32'd0);
      check("rst_id", {30'b0, rsp_id}, 32'd0);
      check("rst_count", {16'b0, op_count}, 32'd0);
      check("rst_ready", {28'b0, req_ready}, 32'd0);

      run_single(0, 8'h7F, 8'h01, 1'b0, 9'h080);
      run_single(2, 8'h80, 8'h01, 1'b1, 9'h17F);
      run_single(2, 8'hFF, 8'hFF, 1'b0, 9'h1FE);
      run_single(3, 8'h80, 8'h80, 1'b0, 9'h100);
      run_single(1, 8'h7F, 8'h80, 1'b1, 9'h0FF);

      // Fair rotation: all four, then only 1 and 3.
      do_reset();
      glog.delete();
      h = hs_cnt;
      for (int i = 0; i < 4; i++)
         set_req(i, 8'($urandom), 8'($urandom), 1'($urandom));
      wait_hs(h + 4);
      req_valid = 4'b1010;
      wait_hs(h + 8);
      req_valid = 4'b0000;
      wait_drain();
      check("order_n", glog.size(), 8);
      for (int i = 0; i < 8 && i < glog.size(); i++)
         check("order", glog[i], exp_order[i]);

      // Backpressure with requester 1 pending.
      rsp_ready = 1'b0;
      h = hs_cnt;
      set_req(2, 8'h12, 8'h34, 1'b1);
      wait_hs(h + 1);
      req_valid[2] = 1'b0;
      set_req(1, 8'h9A, 8'h0B, 1'b0);
      repeat (6) begin
         @(posedge clk); #1;
         check("bp_ready", {28'b0, req_ready}, 32'd0);
      end
      h = hs_cnt;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_grant", {28'b0, req_ready}, 32'h2);
      wait_hs(h + 1);
      req_valid[1] = 1'b0;
      wait_drain();

      // Reset while requester 3 is executing.
      h = hs_cnt;
      set_req(3, 8'h55, 8'h22, 1'b0);
      wait_hs(h + 1);
      req_valid = 4'b0000;
      #2 rst = 1'b1;
      model_reset();
      #1;
      check("rst_drop", {31'b0, rsp_valid}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      h = rsp_cnt;
      for (int i = 0; i < 4; i++)
         set_req(i, 8'($urandom), 8'($urandom), 1'($urandom));
      #1;
      check("rst_grant", {28'b0, req_ready}, 32'h1);
      h = hs_cnt;
      wait_hs(h + 3);
      req_valid = 4'b0000;
      wait_drain();
      check("count3", {16'b0, op_count}, STATS_EN ? 32'd3 : 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
